conv_mac_engine: RTL

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_sat_round.sv | 34 +++
 rtl/conv_mac_engine.sv | 135 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC datapath: control states and
// default numeric format / kernel length.
package conv_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 24;
    localparam int TAPS   = 9;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } convState_e;

endpackage

// File: rtl/conv_sat_round.sv
// Combinational output stage: rescale a wide fixed-point accumulator back to
// DATA_W bits (floor shift), saturate, then optionally clamp negatives to zero.
module conv_sat_round #(
    parameter int ACC_W  = 68,
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int FRAC_W = conv_pkg::FRAC_W
) (
    input  logic [ACC_W-1:0]  accIn,
    input  logic              reluEn,
    output logic [DATA_W-1:0] result
);
    import conv_pkg::*;

    localparam logic signed [ACC_W-1:0] MAX_VAL = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_VAL = ~MAX_VAL;

    logic signed [ACC_W-1:0] shifted;

    assign shifted = $signed(accIn) >>> FRAC_W;

    always_comb begin
        if (shifted > MAX_VAL) begin
            result = MAX_VAL[DATA_W-1:0];
        end else if (shifted < MIN_VAL) begin
            result = MIN_VAL[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
        if (reluEn && result[DATA_W-1]) begin
            result = '0;
        end
    end

endmodule

// File: rtl/conv_mac_engine.sv
// Streaming 1-D convolution MAC: loads a TAPS-long kernel, accumulates one
// window of samples through a registered multiplier, and holds each result.
module conv_mac_engine #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int FRAC_W = conv_pkg::FRAC_W,
    parameter int TAPS   = conv_pkg::TAPS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              dataValid,
    input  logic              filter,
    input  logic              reluEn,
    output logic              dataReady,
    output logic [DATA_W-1:0] dataOut,
    output logic              resultValid,
    input  logic              resultReady
);
    import conv_pkg::*;

    localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);

    convState_e              stateReg, stateNext;
    logic [CNT_W-1:0]        wPtrReg, sCntReg;
    logic signed [DATA_W-1:0] weightMem [TAPS];
    logic signed [PROD_W-1:0] productReg, productNext;
    logic signed [ACC_W-1:0]  accReg, accSum;
    logic                    reluReg;
    logic [DATA_W-1:0]       dataOutReg, satResult;
    logic                    resultValidReg;
    logic                    weightAcc, sampleAcc;

    assign weightAcc   = dataValid & dataReady & filter;
    assign sampleAcc   = dataValid & dataReady & ~filter;
    assign productNext = PROD_W'($signed(dataIn)) * PROD_W'(weightMem[sCntReg]);
    // The multiplier is one cycle ahead of the adder, so each sample folds in the previous product.
    assign accSum      = accReg + ACC_W'(productReg);

    assign dataOut     = dataOutReg;
    assign resultValid = resultValidReg;

    conv_sat_round #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
    ) u_sat (
        .accIn (accSum),
        .reluEn(reluReg),
        .result(satResult)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= ACCUM;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        dataReady = 1'b0;
        case (stateReg)
            ACCUM: begin
                dataReady = 1'b1;
                if (dataValid && !filter && sCntReg == LAST_IDX) begin
                    stateNext = FLUSH;
                end
            end
            FLUSH: stateNext = HOLD;
            HOLD: begin
                if (resultReady) begin
                    stateNext = ACCUM;
                end
            end
            default: stateNext = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wPtrReg        <= '0;
            sCntReg        <= '0;
            accReg         <= '0;
            productReg     <= '0;
            reluReg        <= 1'b0;
            dataOutReg     <= '0;
            resultValidReg <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                weightMem[i] <= '0;
            end
        end else begin
            case (stateReg)
                ACCUM: begin
                    if (weightAcc) begin
                        weightMem[wPtrReg] <= dataIn;
                        wPtrReg <= (wPtrReg == LAST_IDX) ? '0 : wPtrReg + CNT_W'(1);
                        // A kernel change invalidates any half-collected window.
                        if (sCntReg != '0) begin
                            sCntReg    <= '0;
                            accReg     <= '0;
                            productReg <= '0;
                        end
                    end else if (sampleAcc) begin
                        productReg <= productNext;
                        accReg     <= accSum;
                        if (sCntReg == LAST_IDX) begin
                            sCntReg <= '0;
                            reluReg <= reluEn;
                        end else begin
                            sCntReg <= sCntReg + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    accReg         <= accSum;
                    productReg     <= '0;
                    dataOutReg     <= satResult;
                    resultValidReg <= 1'b1;
                end
                HOLD: begin
                    if (resultReady) begin
                        accReg         <= '0;
                        resultValidReg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
